// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared FSM states, access-mask encodings and helpers for dmem_arbiter
package dmem_arb_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_IDLE  = 2'd0;
   localparam arb_state_t ST_ISSUE = 2'd1;
   localparam arb_state_t ST_WAIT  = 2'd2;
   localparam arb_state_t ST_RESP  = 2'd3;

   // bit 2 = unsigned load, bits 1:0 = access size
   typedef enum logic [2:0] {
      MASK_BYTE   = 3'b000,
      MASK_HALF   = 3'b001,
      MASK_WORD   = 3'b010,
      MASK_BYTE_U = 3'b100,
      MASK_HALF_U = 3'b101
   } mem_mask_e;

   localparam int GRANT_CNT_W = 16;

   function automatic logic [GRANT_CNT_W-1:0] sat_inc(input logic [GRANT_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin / fixed-priority request arbiter (one-hot grant plus index)
module rr_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int IDX_W     = 1
) (
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     last_owner,
   input  logic                 rr_mode,
   output logic [NUM_CORES-1:0] grant,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 grant_vld
);
   localparam logic [NUM_CORES-1:0] ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      grant_idx = '0;
      grant_vld = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      if (rr_mode) begin
         // walk from farthest to nearest offset so the nearest pending core wins
         for (int k = NUM_CORES; k >= 1; k--) begin
            cand = int'(last_owner) + k;
            if (cand >= NUM_CORES) cand = cand - NUM_CORES;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
               grant_idx = cand_idx;
               grant_vld = 1'b1;
            end
         end
      end else begin
         for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (req[k]) begin
               grant_idx = IDX_W'(k);
               grant_vld = 1'b1;
            end
         end
      end
      grant = grant_vld ? (ONE << grant_idx) : '0;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - multi-core data-memory arbiter, one outstanding access at a time
// Optional per-core grant counters with DMEM_ARB_STATS_EN.
module dmem_arbiter #(
   parameter int NUM_CORES     = 2,
   parameter int ADDR_W        = 10,
   parameter int DATA_W        = 32,
   parameter int RR_EN_DEFAULT = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        core_rd_en,
   input  logic [NUM_CORES-1:0]        core_wr_en,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   input  logic [NUM_CORES*3-1:0]      core_mask,
   output logic [NUM_CORES-1:0]        core_stall,
   output logic [NUM_CORES-1:0]        core_done,
   output logic [DATA_W-1:0]           core_rdata,
   output logic                        mem_rd_en,
   output logic                        mem_wr_en,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic [2:0]                  mem_mask,
   input  logic [DATA_W-1:0]           mem_rdata,
   input  logic                        mem_ack
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [NUM_CORES*16-1:0]     grant_cnt
`endif
);
   import dmem_arb_pkg::*;

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic RR_MODE = (RR_EN_DEFAULT != 0);
   localparam logic [NUM_CORES-1:0] ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  owner_q, owner_d;
   logic [IDX_W-1:0]  last_owner_q, last_owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [2:0]        mask_q, mask_d;
   logic              op_wr_q, op_wr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [NUM_CORES-1:0] gnt;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_vld;

   rr_arbiter #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_arb (
      .req       (core_rd_en | core_wr_en),
      .last_owner(last_owner_q),
      .rr_mode   (RR_MODE),
      .grant     (gnt),
      .grant_idx (gnt_idx),
      .grant_vld (gnt_vld)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mask_d       = mask_q;
      op_wr_d      = op_wr_q;
      rdata_d      = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               owner_d = gnt_idx;
               for (int i = 0; i < NUM_CORES; i++) begin
                  if (gnt[i]) begin
                     addr_d  = core_addr[i*ADDR_W +: ADDR_W];
                     wdata_d = core_wdata[i*DATA_W +: DATA_W];
                     mask_d  = core_mask[i*3 +: 3];
                  end
               end
               // rd+wr together resolves to a write
               op_wr_d = |(core_wr_en & gnt);
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (mem_ack) begin
               state_d = ST_RESP;
               if (!op_wr_q) rdata_d = mem_rdata;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            last_owner_d = owner_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         last_owner_q <= IDX_W'(NUM_CORES - 1);
         addr_q       <= '0;
         wdata_q      <= '0;
         mask_q       <= '0;
         op_wr_q      <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mask_q       <= mask_d;
         op_wr_q      <= op_wr_d;
         rdata_q      <= rdata_d;
      end
   end

   assign mem_rd_en  = (state_q == ST_ISSUE) && !op_wr_q;
   assign mem_wr_en  = (state_q == ST_ISSUE) && op_wr_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_mask   = mask_q;
   assign core_done  = (state_q == ST_RESP) ? (ONE << owner_q) : '0;
   assign core_rdata = ((state_q == ST_RESP) && !op_wr_q) ? rdata_q : '0;
   assign core_stall = (core_rd_en | core_wr_en) & ~core_done;

`ifdef DMEM_ARB_STATS_EN
   logic [NUM_CORES*16-1:0] grant_cnt_q, grant_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (core_done[i]) grant_cnt_d[i*16 +: 16] = sat_inc(grant_cnt_q[i*16 +: 16]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) grant_cnt_q <= '0;
      else        grant_cnt_q <= grant_cnt_d;
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (RR instance plus fixed-priority instance)
module tb_dmem_arbiter;

   typedef struct {
      int          core;
      bit          wr;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  mask;
      logic [31:0] rdata;
      int          issue_cyc;
      int          done_cyc;
   } txn_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   c_rd, c_wr;
   logic [39:0]  c_addr;
   logic [127:0] c_wdata;
   logic [11:0]  c_mask;
   logic [3:0]   core_stall, core_done;
   logic [31:0]  core_rdata;
   logic         mem_rd_en, mem_wr_en, mem_ack;
   logic [9:0]   mem_addr;
   logic [31:0]  mem_wdata, mem_rdata;
   logic [2:0]   mem_mask;

   logic [3:0]   f_rd;
   logic [3:0]   core_stall2, core_done2;
   logic [31:0]  core_rdata2, mem_wdata2;
   logic         mem_rd_en2, mem_wr_en2, mem_ack2;
   logic [9:0]   mem_addr2;
   logic [2:0]   mem_mask2;
`ifdef DMEM_ARB_STATS_EN
   logic [63:0]  gcnt, gcnt2;
`endif

   int   n_checks = 0, n_pass = 0, cyc = 0;
   txn_t exp_q[$];
   txn_t cur, mh;
   logic [31:0] ref_mem [1024];
   logic [31:0] dev_mem [1024];
   bit   active[4], granted[4];
   bit   busy, rel_pending, mw_wait, stray_en, drop_en, seen;
   int   m_last, cur_delay, mw_cnt, auto_pct, op_force, force_delay, lat;
   logic [9:0] mw_addr;
   logic [3:0] med;
   bit   miss;

   dmem_arbiter #(.NUM_CORES(4), .ADDR_W(10), .DATA_W(32), .RR_EN_DEFAULT(1)) dut (
      .clk(clk), .reset(reset), .core_rd_en(c_rd), .core_wr_en(c_wr), .core_addr(c_addr),
      .core_wdata(c_wdata), .core_mask(c_mask), .core_stall(core_stall), .core_done(core_done),
      .core_rdata(core_rdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DMEM_ARB_STATS_EN
      , .grant_cnt(gcnt)
`endif
   );

   dmem_arbiter #(.NUM_CORES(4), .ADDR_W(10), .DATA_W(32), .RR_EN_DEFAULT(0)) dut_fp (
      .clk(clk), .reset(reset), .core_rd_en(f_rd), .core_wr_en(4'b0), .core_addr(40'h0),
      .core_wdata(128'h0), .core_mask(12'h0), .core_stall(core_stall2), .core_done(core_done2),
      .core_rdata(core_rdata2), .mem_rd_en(mem_rd_en2), .mem_wr_en(mem_wr_en2), .mem_addr(mem_addr2),
      .mem_wdata(mem_wdata2), .mem_mask(mem_mask2), .mem_rdata(32'h1234), .mem_ack(mem_ack2)
`ifdef DMEM_ARB_STATS_EN
      , .grant_cnt(gcnt2)
`endif
   );

   assign mem_ack2 = mem_rd_en2 | mem_wr_en2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
   endtask

   task automatic start_txn(input int i, input int op, input logic [9:0] a,
                            input logic [31:0] wd, input logic [2:0] mk);
      active[i]  = 1'b1;
      granted[i] = 1'b0;
      c_rd[i] = (op != 1);
      c_wr[i] = (op != 0);
      c_addr[i*10 +: 10]   = a;
      c_wdata[i*32 +: 32]  = wd;
      c_mask[i*3 +: 3]     = mk;
   endtask

   task automatic start_rand(input int i);
      int op;
      op = (op_force >= 0) ? op_force : int'($urandom_range(0, 2));
      start_txn(i, op, 10'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 7)));
   endtask

   // per-negedge stimulus: memory device, core behaviour, reference arbitration
   task automatic body();
      int w, d;
      txn_t t;
      logic [3:0] req;
      if (rel_pending) begin reset = 1'b1; rel_pending = 1'b0; end
      mem_ack = 1'b0;
      if (mw_wait) begin
         mw_cnt--;
         if (mw_cnt == 0) begin mem_ack = 1'b1; mem_rdata = dev_mem[mw_addr]; mw_wait = 1'b0; end
      end else if (mem_rd_en || mem_wr_en) begin
         mw_addr = mem_addr;
         if (mem_wr_en) dev_mem[mem_addr] = mem_wdata;
         mw_cnt = cur_delay;
         if (mw_cnt == 0) begin mem_ack = 1'b1; mem_rdata = dev_mem[mw_addr]; end
         else mw_wait = 1'b1;
      end else if (stray_en && $urandom_range(0, 4) == 0) begin
         mem_ack = 1'b1;
         mem_rdata = $urandom;
      end
      if (busy && cyc == cur.done_cyc) begin
         active[cur.core] = 1'b0; granted[cur.core] = 1'b0;
         c_rd[cur.core] = 1'b0;   c_wr[cur.core] = 1'b0;
      end
      if (busy && cyc == cur.done_cyc + 1) busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!active[i] && int'($urandom_range(0, 99)) < auto_pct) start_rand(i);
         else if (granted[i] && drop_en && $urandom_range(0, 9) == 0) begin c_rd[i] = 1'b0; c_wr[i] = 1'b0; end
      end
      req = c_rd | c_wr;
      if (reset && !busy && req != 4'b0) begin
         w = -1;
         for (int k = 1; k <= 4; k++) if (w < 0 && req[(m_last + k) % 4]) w = (m_last + k) % 4;
         m_last = w;
         d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
         t.core = w; t.wr = c_wr[w];
         t.addr = c_addr[w*10 +: 10]; t.wdata = c_wdata[w*32 +: 32]; t.mask = c_mask[w*3 +: 3];
         t.rdata = t.wr ? 32'h0 : ref_mem[t.addr];
         if (t.wr) ref_mem[t.addr] = t.wdata;
         t.issue_cyc = cyc + 1; t.done_cyc = cyc + 2 + d;
         exp_q.push_back(t);
         cur = t; cur_delay = d; busy = 1'b1; granted[w] = 1'b1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      body();
   endtask

   task automatic drain();
      bit any;
      for (int k = 0; k < 300; k++) begin
         any = busy;
         for (int i = 0; i < 4; i++) any |= active[i];
         if (!any) break;
         tick();
      end
      any = busy;
      for (int i = 0; i < 4; i++) any |= active[i];
      chk(!any, "drain_timeout", any, 0);
   endtask

   task automatic run_lat(input int i, input int op, input logic [9:0] a, input int dly,
                          input int exp_lat, input string nm);
      force_delay = dly;
      @(negedge clk);
      start_txn(i, op, a, 32'hA5A5_0000 | 32'(i), 3'd2);
      body();
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         lat++;
         if (core_done[i]) break;
      end
      chk(lat == exp_lat, nm, lat, exp_lat);
      drain();
   endtask

   // scoreboard monitor, sampled just after the active edge
   always @(posedge clk) begin
      #1;
      if (reset) begin
         med  = 4'b0;
         miss = 1'b1;
         if (exp_q.size() > 0) begin
            mh   = exp_q[0];
            miss = (mh.issue_cyc != cyc);
            if (mh.done_cyc == cyc) med = 4'b1 << mh.core;
         end
         chk(core_done == med, "core_done", core_done, med);
         chk(core_stall == ((c_rd | c_wr) & ~med), "core_stall", core_stall, (c_rd | c_wr) & ~med);
         if (!miss) begin
            chk({mem_rd_en, mem_wr_en} == (mh.wr ? 2'b01 : 2'b10), "issue_en", {mem_rd_en, mem_wr_en}, mh.wr ? 2'b01 : 2'b10);
            chk(mem_addr == mh.addr, "issue_addr", mem_addr, mh.addr);
            chk(mem_wdata == mh.wdata, "issue_wdata", mem_wdata, mh.wdata);
            chk(mem_mask == mh.mask, "issue_mask", mem_mask, mh.mask);
         end else begin
            chk({mem_rd_en, mem_wr_en} == 2'b00, "idle_en", {mem_rd_en, mem_wr_en}, 0);
         end
         if (med != 4'b0) begin
            chk(core_rdata == mh.rdata, "core_rdata", core_rdata, mh.rdata);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin ref_mem[i] = 32'h0; dev_mem[i] = 32'h0; end
      c_rd = 0; c_wr = 0; c_addr = 0; c_wdata = 0; c_mask = 0;
      mem_ack = 0; mem_rdata = 0; f_rd = 0;
      busy = 0; rel_pending = 0; mw_wait = 0; mw_cnt = 0; mw_addr = 0; cur_delay = 0;
      stray_en = 0; drop_en = 0; auto_pct = 0; op_force = 1; force_delay = -1; m_last = 3;
      for (int i = 0; i < 4; i++) begin active[i] = 0; granted[i] = 0; end
      for (int i = 0; i < 4; i++) start_txn(i, 1, 10'(40 + i), $urandom, 3'd2);
      #1 reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk({mem_rd_en, mem_wr_en, mem_rd_en2, mem_wr_en2} == 4'b0, "rst_mem_en", {mem_rd_en, mem_wr_en}, 0);
         chk(core_done == 0 && core_rdata == 0, "rst_done", {core_done, core_rdata}, 0);
         chk(mem_addr == 0 && mem_wdata == 0 && mem_mask == 0, "rst_fields", {mem_addr, mem_wdata}, 0);
         chk(core_stall == (c_rd | c_wr), "rst_stall", core_stall, c_rd | c_wr);
      end
      // all cores writing continuously: RR order 0,1,2,3,0,...
      rel_pending = 1'b1;
      auto_pct = 100;
      repeat (30) tick();
      auto_pct = 0;
      drain();
      dev_mem[16] = 32'hDEADBEEF;
      ref_mem[16] = 32'hDEADBEEF;
      run_lat(1, 0, 10'h010, 2, 4, "read_latency");
      run_lat(3, 1, 10'h020, 0, 2, "ack_in_issue_latency");
      run_lat(2, 2, 10'h010, 1, 3, "rdwr_as_write_latency");
      run_lat(0, 0, 10'h010, 0, 2, "read_back_latency");
      // randomized traffic with drops, stray acks and variable memory latency
      op_force = -1; force_delay = -1; auto_pct = 30; drop_en = 1; stray_en = 1;
      repeat (400) tick();
      auto_pct = 0; drop_en = 0; stray_en = 0;
      drain();
      // reset while a read is waiting on memory
      force_delay = 4;
      @(negedge clk);
      start_txn(2, 0, 10'h011, 32'h0, 3'd2);
      body();
      for (int k = 0; k < 10 && !mw_wait; k++) tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
      busy = 0; mw_wait = 0; mem_ack = 0; m_last = 3;
      for (int i = 0; i < 4; i++) begin active[i] = 0; granted[i] = 0; end
      c_rd = 0; c_wr = 0;
      repeat (2) tick();
      force_delay = -1;
      @(negedge clk);
      rel_pending = 1'b1;
      for (int i = 0; i < 4; i++) start_txn(3 - i, 0, 10'(i), 32'h0, 3'd2);
      body();
      drain();
      // fixed priority instance: core 2 starved while core 0 keeps requesting
      f_rd = 4'b0101;
      repeat (24) begin
         @(negedge clk);
         if (core_done2 != 4'b0) chk(core_done2 == 4'b0001, "fixed_prio", core_done2, 4'b0001);
      end
      f_rd = 4'b0100;
      seen = 0;
      for (int k = 0; k < 12 && !seen; k++) begin
         @(negedge clk);
         if (core_done2[2]) seen = 1;
      end
      chk(seen, "fixed_core2_served", seen, 1);
      f_rd = 4'b0;
      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: NUM_CORES, default 2, requesting core count (2..8); ADDR_W, default 10, word-address width; DATA_W, default 32, data width; RR_EN_DEFAULT, default 1, 1 = round-robin, 0 = fixed priority (core 0 highest).
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-003 SHALL have ports: core_rd_en, core_wr_en  in  NUM_CORES  per-core read/write request.
REQ-004 SHALL have ports: core_addr  in  NUM_CORES*ADDR_W; core_wdata  in  NUM_CORES*DATA_W; core_mask  in  NUM_CORES*3  per-core address/data/byte mask.
REQ-005 SHALL have ports: core_stall  out  NUM_CORES  hold request, freeze PC; core_done  out  NUM_CORES  one-cycle completion pulse; core_rdata  out  DATA_W  read data, valid with core_done.
REQ-006 SHALL have ports: mem_rd_en, mem_wr_en  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_mask  out  3; mem_rdata  in  DATA_W; mem_ack  in  1  memory completion.

Function
REQ-007 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-008 In IDLE, any pending request SHALL be arbitrated; the winner SHALL be latched into owner, addr, wdata, mask and op registers, then FSM -> ISSUE.
REQ-009 Round-robin SHALL search from (last_owner+1) mod NUM_CORES upward with wrap-around; fixed priority SHALL pick the lowest pending index.
REQ-010 ISSUE SHALL drive mem_rd_en or mem_wr_en for exactly one cycle with the latched fields, then -> WAIT.
REQ-011 In WAIT, outputs SHALL hold the latched fields with enables low; mem_ack SHALL move FSM -> RESP and capture mem_rdata for reads.
REQ-012 mem_ack seen in ISSUE SHALL be accepted as completion (skip WAIT, go to RESP).
REQ-013 RESP SHALL assert core_done[owner] for one cycle with core_rdata (reads) or 0 (writes), update last_owner, return to IDLE.
REQ-014 core_stall[i] SHALL be (core_rd_en[i]|core_wr_en[i]) & ~core_done[i], combinational.
REQ-015 Requests asserted with both rd_en and wr_en SHALL be treated as writes.
REQ-016 Minimum request-to-done latency SHALL be 3 cycles (IDLE, ISSUE, RESP with ack in ISSUE); no upper bound.
REQ-017 A request dropped by a core mid-transaction SHALL not abort the memory access; core_done still pulses.
REQ-018 Only one memory transaction SHALL be outstanding; mem_ack outside ISSUE/WAIT SHALL be ignored.

Reset
REQ-019 On reset low, FSM = IDLE, last_owner = NUM_CORES-1, all latched registers, mem_*_en, core_done, core_rdata = 0, immediately and asynchronously.
REQ-020 Reset mid-transaction SHALL abandon it silently; no core_done issued after release.

Configuration
REQ-021 With DMEM_ARB_STATS_EN defined, SHALL add output grant_cnt (NUM_CORES*16), per-core saturating grant counters incremented in RESP, cleared by reset.
REQ-022 Without DMEM_ARB_STATS_EN, grant_cnt and its counters SHALL not exist.

Structure
REQ-023 Shared package dmem_arb_pkg SHALL hold the FSM state enum and mask encodings (byte/half/word, signed/unsigned).
REQ-024 Arbitration SHALL be a sub-module rr_arbiter (request vector, last_owner, mode -> one-hot grant, index).

Verification
REQ-025 Reset: hold reset low 3 cycles with requests active -> all outputs 0, FSM IDLE, no mem enable.
REQ-026 Single read: core 1 reads addr 0x010, mem_ack 2 cycles after mem_rd_en, mem_rdata 0xDEADBEEF -> core_done[1] with rdata 0xDEADBEEF, core_stall[1] high until then.
REQ-027 Contention RR, NUM_CORES=4: all cores write continuously -> grant order 0,1,2,3,0; no core starved.
REQ-028 Fixed priority: cores 0 and 2 request continuously -> core 2 never granted while core 0 requests.
REQ-029 Ack in ISSUE: mem_ack same cycle as mem_wr_en -> core_done exactly 3 cycles after request.
REQ-030 Reset in WAIT: assert reset low during WAIT -> no core_done after release, next grant from core 0.
